demo_gpio_bank: RTL



---
 rtl/gpio_bank_pkg.sv | 24 ++
 rtl/gpio_debounce.sv | 57 +++++
 rtl/demo_gpio_bank.sv | 125 ++++++++++++
 3 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared register map, interrupt bit position and sizing helper for demo_gpio_bank.
// Pure declarations: no latency, no flow control.
package gpio_bank_pkg;

    localparam logic [2:0] REG_LED_DATA     = 3'd0;
    localparam logic [2:0] REG_BLINK_MASK   = 3'd1;
    localparam logic [2:0] REG_BLINK_PERIOD = 3'd2;
    localparam logic [2:0] REG_SW_STATE     = 3'd3;
    localparam logic [2:0] REG_KEY_STATE    = 3'd4;
    localparam logic [2:0] REG_SW_EDGE      = 3'd5;
    localparam logic [2:0] REG_KEY_EDGE     = 3'd6;
    localparam logic [2:0] REG_IRQ_MASK     = 3'd7;

    localparam int IRQ_KEY_BIT = 31;

    // Smallest width (at least 1) whose range covers 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-channel 2-flop synchroniser plus debounce counter with one-cycle change pulse.
// Latency 2 + DEBOUNCE_CYCLES from pin to pulse; no backpressure, pulse is fire-and-forget.
module gpio_debounce
    import gpio_bank_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter bit INVERT          = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] change_o
);

    localparam int             CW      = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] change_q;
    logic [CW-1:0]    cnt_q [WIDTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            change_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            // Polarity is fixed before synchronising so "stable = 0" always means idle.
            sync1_q <= pins_i ^ {WIDTH{INVERT}};
            sync2_q <= sync1_q;
            for (int i = 0; i < WIDTH; i++) begin
                change_q[i] <= 1'b0;
                if (sync2_q[i] != stable_q[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        stable_q[i] <= sync2_q[i];
                        change_q[i] <= 1'b1;
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign stable_o = stable_q;
    assign change_o = change_q;

endmodule

// File: rtl/demo_gpio_bank.sv
// Avalon-MM GPIO bank: LEDs with blink, debounced switches/keys, W1C edge capture, maskable irq.
// Read latency 1, writes visible next cycle, leds one cycle later; no waitrequest, never stalls.
module demo_gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int NUM_LEDS        = 10,
    parameter int NUM_SWITCHES    = 10,
    parameter int NUM_KEYS        = 3,
    parameter bit KEYS_ACTIVE_LOW = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [2:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic                    irq,
    output logic [NUM_LEDS-1:0]     leds_new_signal,
    input  logic [NUM_SWITCHES-1:0] switches_new_signal,
    input  logic [NUM_KEYS-1:0]     keys_new_signal
);

    localparam logic [31:0] IRQ_MASK_WMASK =
        32'((64'd1 << NUM_SWITCHES) - 64'd1) | (32'd1 << IRQ_KEY_BIT);

    logic [NUM_LEDS-1:0]     led_data_q, blink_mask_q, leds_q;
    logic [31:0]             blink_period_q, blink_cnt_q, irq_mask_q, readdata_q, rd_mux;
    logic                    phase_q, irq_q;
    logic [NUM_SWITCHES-1:0] sw_stable, sw_change, sw_edge_q, sw_edge_d, sw_clr;
    logic [NUM_KEYS-1:0]     key_stable, key_change, key_edge_q, key_edge_d, key_clr;

    gpio_debounce #(.WIDTH(NUM_SWITCHES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b0)) u_sw_db (
        .clk_i(clk_clk), .rst_i(reset_reset), .pins_i(switches_new_signal),
        .stable_o(sw_stable), .change_o(sw_change)
    );

    gpio_debounce #(.WIDTH(NUM_KEYS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(KEYS_ACTIVE_LOW)) u_key_db (
        .clk_i(clk_clk), .rst_i(reset_reset), .pins_i(keys_new_signal),
        .stable_o(key_stable), .change_o(key_change)
    );

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            REG_LED_DATA:     rd_mux = 32'(led_data_q);
            REG_BLINK_MASK:   rd_mux = 32'(blink_mask_q);
            REG_BLINK_PERIOD: rd_mux = blink_period_q;
            REG_SW_STATE:     rd_mux = 32'(sw_stable);
            REG_KEY_STATE:    rd_mux = 32'(key_stable);
            REG_SW_EDGE:      rd_mux = 32'(sw_edge_q);
            REG_KEY_EDGE:     rd_mux = 32'(key_edge_q);
            REG_IRQ_MASK:     rd_mux = irq_mask_q;
            default:          rd_mux = '0;
        endcase
    end

    // Set is OR-ed in after the clear so a coincident change pulse wins.
    always_comb begin
        sw_clr     = (avs_write && avs_address == REG_SW_EDGE)  ? avs_writedata[NUM_SWITCHES-1:0] : '0;
        key_clr    = (avs_write && avs_address == REG_KEY_EDGE) ? avs_writedata[NUM_KEYS-1:0]     : '0;
        sw_edge_d  = (sw_edge_q & ~sw_clr) | sw_change;
        key_edge_d = (key_edge_q & ~key_clr) | (key_change & key_stable);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            led_data_q     <= '0;
            blink_mask_q   <= '0;
            blink_period_q <= '0;
            irq_mask_q     <= '0;
            sw_edge_q      <= '0;
            key_edge_q     <= '0;
            readdata_q     <= '0;
        end else begin
            if (avs_read) readdata_q <= rd_mux;
            if (avs_write) begin
                case (avs_address)
                    REG_LED_DATA:     led_data_q     <= avs_writedata[NUM_LEDS-1:0];
                    REG_BLINK_MASK:   blink_mask_q   <= avs_writedata[NUM_LEDS-1:0];
                    REG_BLINK_PERIOD: blink_period_q <= avs_writedata;
                    REG_IRQ_MASK:     irq_mask_q     <= avs_writedata & IRQ_MASK_WMASK;
                    default:          ;
                endcase
            end
            sw_edge_q  <= sw_edge_d;
            key_edge_q <= key_edge_d;
        end
    end

    // Compare with >= so shrinking the period mid-count still wraps promptly.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (avs_write && avs_address == REG_BLINK_PERIOD) begin
            blink_cnt_q <= '0;
        end else if (blink_period_q == 32'd0) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (blink_cnt_q >= blink_period_q - 32'd1) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            leds_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            leds_q <= led_data_q & (~blink_mask_q | {NUM_LEDS{phase_q}});
            irq_q  <= (|(sw_edge_q & irq_mask_q[NUM_SWITCHES-1:0]))
                    | (irq_mask_q[IRQ_KEY_BIT] & (|key_edge_q));
        end
    end

    assign avs_readdata    = readdata_q;
    assign irq             = irq_q;
    assign leds_new_signal = leds_q;

endmodule
